// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage for an RV64 pipeline.
//
// Purpose:
//   Accepts the MEM_* register set from execute and produces the WB_* register set
//   for writeback. Non-memory instructions pass straight through in one cycle.
//   Loads and stores are sent out over a req/ack data-memory port. Load data is
//   aligned to bit 0 and then sign- or zero-extended. Store byte strobes and store
//   data are placed on the correct byte lanes. Misaligned accesses and accesses
//   whose acknowledge never arrives are flagged to writeback.
//
// Ports:
//   clk, RESET        clock; synchronous active-high reset
//   MEM_*             instruction and operands from execute
//   V_MEM_STALL       combinational; 1 holds execute while an access is in flight
//   DMEM_REQ/WE/ADDR/WDATA/WSTRB  registered request, held constant until DMEM_ACK
//   DMEM_RDATA/ACK    memory response; ACK may arrive in the same cycle as REQ
//   WB_*              registered results for writeback
//   dbg_state         current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: a request is presented while DMEM_REQ=1. The request completes in
// the first cycle in which DMEM_REQ=1 and DMEM_ACK=1, and DMEM_RDATA is sampled
// in that same cycle. DMEM_ACK is ignored whenever DMEM_REQ=0.

module mem_stage #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        MEM_V,
   input  logic [31:0] MEM_IR,
   input  logic [63:0] MEM_NPC,
   input  logic [63:0] MEM_ALU_RESULT,
   input  logic [63:0] MEM_SR2,
   input  logic [63:0] MEM_CSRFD,
   input  logic [63:0] MEM_RFD,
   input  logic        MEM_ECALL,
   output logic        V_MEM_STALL,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [63:0] DMEM_ADDR,
   output logic [63:0] DMEM_WDATA,
   output logic [7:0]  DMEM_WSTRB,
   input  logic [63:0] DMEM_RDATA,
   input  logic        DMEM_ACK,
   output logic        WB_V,
   output logic [31:0] WB_IR,
   output logic [63:0] WB_NPC,
   output logic [63:0] WB_ALU_RESULT,
   output logic [63:0] WB_CSRFD,
   output logic [63:0] WB_RFD,
   output logic        WB_ECALL,
   output logic [63:0] WB_MEM_DATA,
   output logic        WB_MISALIGN,
   output logic        WB_BUSERR,
   output logic        dbg_state
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] ctx_ir_q, ctx_ir_d;
   logic [63:0] ctx_npc_q, ctx_npc_d;
   logic [63:0] ctx_alu_q, ctx_alu_d;
   logic [63:0] ctx_csrfd_q, ctx_csrfd_d;
   logic [63:0] ctx_rfd_q, ctx_rfd_d;
   logic        ctx_ecall_q, ctx_ecall_d;

   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [63:0] dmem_addr_q, dmem_addr_d;
   logic [63:0] dmem_wdata_q, dmem_wdata_d;
   logic [7:0]  dmem_wstrb_q, dmem_wstrb_d;

   logic        wb_v_q, wb_v_d;
   logic [31:0] wb_ir_q, wb_ir_d;
   logic [63:0] wb_npc_q, wb_npc_d;
   logic [63:0] wb_alu_q, wb_alu_d;
   logic [63:0] wb_csrfd_q, wb_csrfd_d;
   logic [63:0] wb_rfd_q, wb_rfd_d;
   logic        wb_ecall_q, wb_ecall_d;
   logic [63:0] wb_mem_data_q, wb_mem_data_d;
   logic        wb_misalign_q, wb_misalign_d;
   logic        wb_buserr_q, wb_buserr_d;

   // Decode of the incoming instruction
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [2:0]  off;
   logic        is_load, is_store, is_mem, misalign, start;
   logic [7:0]  strb_base;
   logic        expire;
   logic [2:0]  ctx_f3, ctx_off;
   logic [63:0] ld_shift, ld_data;

   assign opcode   = MEM_IR[6:0];
   assign funct3   = MEM_IR[14:12];
   assign off      = MEM_ALU_RESULT[2:0];
   assign is_load  = (opcode == 7'b0000011) && (funct3 != 3'd7);
   assign is_store = (opcode == 7'b0100011) && !funct3[2];
   assign is_mem   = is_load || is_store;
   assign start    = MEM_V && is_mem && !misalign;

   // funct3[1:0] is log2(size) for every load and store variant.
   always_comb begin
      misalign  = 1'b0;
      strb_base = 8'h00;
      case (funct3[1:0])
         2'd0: begin misalign = 1'b0;          strb_base = 8'h01; end
         2'd1: begin misalign = off[0];        strb_base = 8'h03; end
         2'd2: begin misalign = |off[1:0];     strb_base = 8'h0F; end
         default: begin misalign = |off;       strb_base = 8'hFF; end
      endcase
   end

   // The timeout fires in the WAIT cycle that would bring the count up to ACK_TIMEOUT.
   assign expire = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   // Load alignment uses the latched access, because MEM_* is ignored while in WAIT.
   assign ctx_f3   = ctx_ir_q[14:12];
   assign ctx_off  = ctx_alu_q[2:0];
   assign ld_shift = DMEM_RDATA >> {ctx_off, 3'b000};

   always_comb begin
      ld_data = ld_shift;
      case (ctx_f3)
         3'd0: ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
         3'd1: ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
         3'd2: ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
         3'd4: ld_data = {56'd0, ld_shift[7:0]};
         3'd5: ld_data = {48'd0, ld_shift[15:0]};
         3'd6: ld_data = {32'd0, ld_shift[31:0]};
         default: ld_data = ld_shift;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         ctx_ir_q      <= '0;
         ctx_npc_q     <= '0;
         ctx_alu_q     <= '0;
         ctx_csrfd_q   <= '0;
         ctx_rfd_q     <= '0;
         ctx_ecall_q   <= 1'b0;
         dmem_req_q    <= 1'b0;
         dmem_we_q     <= 1'b0;
         dmem_addr_q   <= '0;
         dmem_wdata_q  <= '0;
         dmem_wstrb_q  <= '0;
         wb_v_q        <= 1'b0;
         wb_ir_q       <= '0;
         wb_npc_q      <= '0;
         wb_alu_q      <= '0;
         wb_csrfd_q    <= '0;
         wb_rfd_q      <= '0;
         wb_ecall_q    <= 1'b0;
         wb_mem_data_q <= '0;
         wb_misalign_q <= 1'b0;
         wb_buserr_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ctx_ir_q      <= ctx_ir_d;
         ctx_npc_q     <= ctx_npc_d;
         ctx_alu_q     <= ctx_alu_d;
         ctx_csrfd_q   <= ctx_csrfd_d;
         ctx_rfd_q     <= ctx_rfd_d;
         ctx_ecall_q   <= ctx_ecall_d;
         dmem_req_q    <= dmem_req_d;
         dmem_we_q     <= dmem_we_d;
         dmem_addr_q   <= dmem_addr_d;
         dmem_wdata_q  <= dmem_wdata_d;
         dmem_wstrb_q  <= dmem_wstrb_d;
         wb_v_q        <= wb_v_d;
         wb_ir_q       <= wb_ir_d;
         wb_npc_q      <= wb_npc_d;
         wb_alu_q      <= wb_alu_d;
         wb_csrfd_q    <= wb_csrfd_d;
         wb_rfd_q      <= wb_rfd_d;
         wb_ecall_q    <= wb_ecall_d;
         wb_mem_data_q <= wb_mem_data_d;
         wb_misalign_q <= wb_misalign_d;
         wb_buserr_q   <= wb_buserr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_WAIT;
         S_WAIT: if (DMEM_ACK || expire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath logic. Writeback defaults to an all-zero bubble.
   always_comb begin
      V_MEM_STALL   = 1'b0;
      cnt_d         = cnt_q;
      ctx_ir_d      = ctx_ir_q;
      ctx_npc_d     = ctx_npc_q;
      ctx_alu_d     = ctx_alu_q;
      ctx_csrfd_d   = ctx_csrfd_q;
      ctx_rfd_d     = ctx_rfd_q;
      ctx_ecall_d   = ctx_ecall_q;
      dmem_req_d    = dmem_req_q;
      dmem_we_d     = dmem_we_q;
      dmem_addr_d   = dmem_addr_q;
      dmem_wdata_d  = dmem_wdata_q;
      dmem_wstrb_d  = dmem_wstrb_q;
      wb_v_d        = 1'b0;
      wb_ir_d       = '0;
      wb_npc_d      = '0;
      wb_alu_d      = '0;
      wb_csrfd_d    = '0;
      wb_rfd_d      = '0;
      wb_ecall_d    = 1'b0;
      wb_mem_data_d = '0;
      wb_misalign_d = 1'b0;
      wb_buserr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               V_MEM_STALL  = 1'b1;
               cnt_d        = '0;
               ctx_ir_d     = MEM_IR;
               ctx_npc_d    = MEM_NPC;
               ctx_alu_d    = MEM_ALU_RESULT;
               ctx_csrfd_d  = MEM_CSRFD;
               ctx_rfd_d    = MEM_RFD;
               ctx_ecall_d  = MEM_ECALL;
               dmem_req_d   = 1'b1;
               dmem_we_d    = is_store;
               dmem_addr_d  = {MEM_ALU_RESULT[63:3], 3'b000};
               dmem_wdata_d = is_store ? (MEM_SR2 << {off, 3'b000}) : 64'd0;
               dmem_wstrb_d = is_store ? (strb_base << off) : 8'h00;
            end else if (MEM_V) begin
               // Non-memory ops and misaligned accesses both complete in one cycle.
               wb_v_d        = 1'b1;
               wb_ir_d       = MEM_IR;
               wb_npc_d      = MEM_NPC;
               wb_alu_d      = MEM_ALU_RESULT;
               wb_csrfd_d    = MEM_CSRFD;
               wb_rfd_d      = MEM_RFD;
               wb_ecall_d    = MEM_ECALL;
               wb_misalign_d = is_mem && misalign;
            end
         end
         S_WAIT: begin
            if (DMEM_ACK || expire) begin
               // An ACK in the expiry cycle wins over the bus error.
               wb_v_d        = 1'b1;
               wb_ir_d       = ctx_ir_q;
               wb_npc_d      = ctx_npc_q;
               wb_alu_d      = ctx_alu_q;
               wb_csrfd_d    = ctx_csrfd_q;
               wb_rfd_d      = ctx_rfd_q;
               wb_ecall_d    = ctx_ecall_q;
               wb_mem_data_d = (DMEM_ACK && !dmem_we_q) ? ld_data : 64'd0;
               wb_buserr_d   = !DMEM_ACK;
               V_MEM_STALL   = !DMEM_ACK;
               cnt_d         = '0;
               dmem_req_d    = 1'b0;
               dmem_we_d     = 1'b0;
               dmem_addr_d   = '0;
               dmem_wdata_d  = '0;
               dmem_wstrb_d  = '0;
            end else begin
               V_MEM_STALL = 1'b1;
               cnt_d       = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign DMEM_REQ      = dmem_req_q;
   assign DMEM_WE       = dmem_we_q;
   assign DMEM_ADDR     = dmem_addr_q;
   assign DMEM_WDATA    = dmem_wdata_q;
   assign DMEM_WSTRB    = dmem_wstrb_q;
   assign WB_V          = wb_v_q;
   assign WB_IR         = wb_ir_q;
   assign WB_NPC        = wb_npc_q;
   assign WB_ALU_RESULT = wb_alu_q;
   assign WB_CSRFD      = wb_csrfd_q;
   assign WB_RFD        = wb_rfd_q;
   assign WB_ECALL      = wb_ecall_q;
   assign WB_MEM_DATA   = wb_mem_data_q;
   assign WB_MISALIGN   = wb_misalign_q;
   assign WB_BUSERR     = wb_buserr_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed memory transactions with a transaction-level
// reference model, a per-cycle compare process, and literal spot checks.

module tb_mem_stage;

   localparam int TO = 4;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        RESET;
   logic        MEM_V;
   logic [31:0] MEM_IR;
   logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
   logic        MEM_ECALL;
   logic        V_MEM_STALL, DMEM_REQ, DMEM_WE;
   logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
   logic [7:0]  DMEM_WSTRB;
   logic        DMEM_ACK;
   logic        WB_V, WB_ECALL, WB_MISALIGN, WB_BUSERR, dbg_state;
   logic [31:0] WB_IR;
   logic [63:0] WB_NPC, WB_ALU_RESULT, WB_CSRFD, WB_RFD, WB_MEM_DATA;

   int total = 0;
   int bad   = 0;

   mem_stage #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .RESET(RESET), .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
      .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2), .MEM_CSRFD(MEM_CSRFD),
      .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL), .V_MEM_STALL(V_MEM_STALL),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_RDATA(DMEM_RDATA),
      .DMEM_ACK(DMEM_ACK), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
      .WB_ALU_RESULT(WB_ALU_RESULT), .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD),
      .WB_ECALL(WB_ECALL), .WB_MEM_DATA(WB_MEM_DATA), .WB_MISALIGN(WB_MISALIGN),
      .WB_BUSERR(WB_BUSERR), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference functions (byte-level) ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
      logic [63:0] v;
      int sz;
      sz = size_of(f3);
      v = 64'd0;
      for (int k = 0; k < sz; k++)
         if (off + k < 8) v[8*k +: 8] = rd[8*(off+k) +: 8];
      if (f3 < 3'd3 && v[8*sz-1])
         for (int k = sz; k < 8; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [7:0] ref_strb(input int sz, input int off);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 8; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] sr2, input int off);
      logic [63:0] w;
      w = 64'd0;
      for (int i = off; i < 8; i++) w[8*i +: 8] = sr2[8*(i-off) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
      return {12'h0A5, 5'd3, f3, 5'd9, op};
   endfunction

   // ---------------- reference model ----------------
   bit          m_started = 0;
   bit          m_busy = 0;
   int          m_wait = 0;
   bit          m_full = 0;
   logic [31:0] t_ir;
   logic [63:0] t_npc, t_alu, t_csrfd, t_rfd;
   logic        t_ecall, t_load;
   logic        e_req, e_we, e_wb_v, e_ecall, e_mis, e_berr;
   logic [63:0] e_addr, e_wdata, e_npc, e_alu, e_csrfd, e_rfd, e_mdata;
   logic [7:0]  e_strb;
   logic [31:0] e_ir;

   function automatic bit dec_mem(input logic [31:0] ir, output bit ld, output bit st);
      ld = (ir[6:0] == OP_LOAD) && (ir[14:12] != 3'd7);
      st = (ir[6:0] == OP_STORE) && (ir[14:12] < 3'd4);
      return ld || st;
   endfunction

   function automatic bit aligned(input logic [31:0] ir, input logic [63:0] a);
      return (int'(a[2:0]) % size_of(ir[14:12])) == 0;
   endfunction

   task automatic wb_zero();
      e_wb_v = 0; e_ir = 0; e_npc = 0; e_alu = 0; e_csrfd = 0; e_rfd = 0;
      e_ecall = 0; e_mdata = 0; e_mis = 0; e_berr = 0;
   endtask

   task automatic wb_from_txn(input logic [63:0] mdata, input logic berr);
      e_wb_v = 1; e_ir = t_ir; e_npc = t_npc; e_alu = t_alu; e_csrfd = t_csrfd;
      e_rfd = t_rfd; e_ecall = t_ecall; e_mdata = mdata; e_mis = 0; e_berr = berr;
      m_full = 1; m_busy = 0; e_req = 0;
   endtask

   task automatic model_step();
      bit ld, st, mem;
      m_started = 1;
      if (RESET) begin
         m_busy = 0; m_wait = 0; e_req = 0; e_we = 0; m_full = 1; wb_zero();
      end else if (!m_busy) begin
         mem = dec_mem(MEM_IR, ld, st);
         if (MEM_V && mem && aligned(MEM_IR, MEM_ALU_RESULT)) begin
            m_busy = 1; m_wait = 0;
            t_ir = MEM_IR; t_npc = MEM_NPC; t_alu = MEM_ALU_RESULT; t_csrfd = MEM_CSRFD;
            t_rfd = MEM_RFD; t_ecall = MEM_ECALL; t_load = ld;
            e_req = 1; e_we = st; e_addr = MEM_ALU_RESULT & ~64'h7;
            e_wdata = st ? ref_wdata(MEM_SR2, int'(MEM_ALU_RESULT[2:0])) : 64'd0;
            e_strb = st ? ref_strb(size_of(MEM_IR[14:12]), int'(MEM_ALU_RESULT[2:0])) : 8'h00;
            wb_zero(); m_full = 0;
         end else if (MEM_V) begin
            e_req = 0; m_full = 1;
            e_wb_v = 1; e_ir = MEM_IR; e_npc = MEM_NPC; e_alu = MEM_ALU_RESULT;
            e_csrfd = MEM_CSRFD; e_rfd = MEM_RFD; e_ecall = MEM_ECALL; e_mdata = 0;
            e_mis = mem; e_berr = 0;
         end else begin
            e_req = 0; m_full = 1; wb_zero();
         end
      end else if (DMEM_ACK) begin
         wb_from_txn(t_load ? ref_load(t_ir[14:12], int'(t_alu[2:0]), DMEM_RDATA) : 64'd0, 1'b0);
      end else begin
         m_wait++;
         if (m_wait >= TO) wb_from_txn(64'd0, 1'b1);
         else begin e_wb_v = 0; m_full = 0; end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (m_started) begin
         bit ld, st, mem;
         logic exp_stall;
         chk("req", DMEM_REQ, e_req);
         if (e_req) begin
            chk("we", DMEM_WE, e_we);
            chk("addr", DMEM_ADDR, e_addr);
            if (e_we) begin
               chk("wdata", DMEM_WDATA, e_wdata);
               chk("wstrb", DMEM_WSTRB, e_strb);
            end
         end
         chk("wb_v", WB_V, e_wb_v);
         if (m_full) begin
            chk("wb_ir", WB_IR, e_ir);
            chk("wb_npc", WB_NPC, e_npc);
            chk("wb_alu", WB_ALU_RESULT, e_alu);
            chk("wb_csrfd", WB_CSRFD, e_csrfd);
            chk("wb_rfd", WB_RFD, e_rfd);
            chk("wb_ecall", WB_ECALL, e_ecall);
            chk("wb_mem_data", WB_MEM_DATA, e_mdata);
            chk("wb_misalign", WB_MISALIGN, e_mis);
            chk("wb_buserr", WB_BUSERR, e_berr);
         end
         if (!RESET) begin
            mem = dec_mem(MEM_IR, ld, st);
            exp_stall = m_busy ? !DMEM_ACK : (MEM_V && mem && aligned(MEM_IR, MEM_ALU_RESULT));
            chk("stall", V_MEM_STALL, exp_stall);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sr2);
      MEM_V = 1; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_SR2 = sr2;
      MEM_NPC = alu + 64'h44; MEM_CSRFD = ~alu; MEM_RFD = {alu[31:0], alu[63:32]};
      MEM_ECALL = alu[4];
   endtask

   // One memory op: issue, 'delay' WAIT cycles without ACK, then ACK with rdata.
   task automatic do_mem(input logic [2:0] f3, input bit st, input logic [63:0] addr,
                         input logic [63:0] sr2, input logic [63:0] rdata, input int delay,
                         output int stalls, output logic [63:0] s_addr,
                         output logic [63:0] s_wdata, output logic [7:0] s_strb,
                         output logic s_we);
      stalls = 0;
      step(); drive_op(mk_ir(f3, st ? OP_STORE : OP_LOAD), addr, sr2); DMEM_ACK = 0;
      @(negedge clk); stalls += int'(V_MEM_STALL);
      for (int k = 0; k < delay; k++) begin
         step(); DMEM_ACK = 0;
         @(negedge clk); stalls += int'(V_MEM_STALL);
         if (k == 0) begin s_addr = DMEM_ADDR; s_wdata = DMEM_WDATA; s_strb = DMEM_WSTRB; s_we = DMEM_WE; end
      end
      step(); DMEM_ACK = 1; DMEM_RDATA = rdata;
      @(negedge clk); stalls += int'(V_MEM_STALL);
      if (delay == 0) begin s_addr = DMEM_ADDR; s_wdata = DMEM_WDATA; s_strb = DMEM_WSTRB; s_we = DMEM_WE; end
      step(); DMEM_ACK = 0; MEM_V = 0; DMEM_RDATA = 64'h5A5A_5A5A_5A5A_5A5A;
      @(negedge clk);
   endtask

   // directed table of additional accesses; results checked by the model
   typedef struct {
      logic [2:0]  f3;
      bit          st;
      logic [63:0] addr;
      logic [63:0] sr2;
      logic [63:0] rdata;
      int          delay;
   } vec_t;

   vec_t vecs[8] = '{
      '{3'd5, 1'b0, 64'h3006, 64'h0, 64'hBEEF_0000_0000_0000, 0},
      '{3'd2, 1'b0, 64'h4004, 64'h0, 64'h8765_4321_0000_0000, 2},
      '{3'd6, 1'b0, 64'h4004, 64'h0, 64'h8765_4321_0000_0000, 1},
      '{3'd3, 1'b0, 64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 3},
      '{3'd4, 1'b0, 64'h5007, 64'h0, 64'hF100_0000_0000_0000, 0},
      '{3'd0, 1'b1, 64'h6005, 64'h77, 64'h0, 1},
      '{3'd2, 1'b1, 64'h6004, 64'hCAFE_F00D, 64'h0, 0},
      '{3'd3, 1'b1, 64'h6008, 64'h1122_3344_5566_7788, 64'h0, 2}
   };

   // ---------------- main sequence ----------------
   initial begin
      int stalls, reqs;
      logic [63:0] s_addr, s_wdata;
      logic [7:0] s_strb;
      logic s_we;

      RESET = 1; MEM_V = 0; MEM_IR = 0; MEM_NPC = 0; MEM_ALU_RESULT = 0; MEM_SR2 = 0;
      MEM_CSRFD = 0; MEM_RFD = 0; MEM_ECALL = 0; DMEM_RDATA = 0; DMEM_ACK = 0;

      // model pins
      chk("ref_lb", ref_load(3'd0, 3, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
      chk("ref_strb_sh", {56'd0, ref_strb(2, 6)}, 64'hC0);
      chk("ref_wdata_sh", ref_wdata(64'hABCD, 6), 64'hABCD_0000_0000_0000);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_wb_v", WB_V, 1'b0);
      chk("reset_req", DMEM_REQ, 1'b0);
      chk("reset_wstrb", DMEM_WSTRB, 8'h00);
      chk("reset_wb_alu", WB_ALU_RESULT, 64'd0);
      step(); RESET = 0;

      // ALU op passes through
      step(); drive_op({12'h000, 5'd2, 3'd0, 5'd1, OP_ALU}, 64'h1234, 64'h0);
      @(negedge clk); chk("add_stall", V_MEM_STALL, 1'b0);
      step(); MEM_V = 0;
      @(negedge clk);
      chk("add_wb_v", WB_V, 1'b1);
      chk("add_wb_alu", WB_ALU_RESULT, 64'h1234);
      chk("add_mem_data", WB_MEM_DATA, 64'd0);
      chk("add_req", DMEM_REQ, 1'b0);

      // LB with ACK one cycle after REQ
      do_mem(3'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, stalls, s_addr, s_wdata, s_strb, s_we);
      chk("lb_data", WB_MEM_DATA, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_stalls", stalls, 2);
      chk("lb_addr", s_addr, 64'h1000);

      // SH with ACK in the same cycle as REQ
      do_mem(3'd1, 1'b1, 64'h2006, 64'hABCD, 64'h0, 0, stalls, s_addr, s_wdata, s_strb, s_we);
      chk("sh_addr", s_addr, 64'h2000);
      chk("sh_wstrb", s_strb, 8'hC0);
      chk("sh_wdata", s_wdata, 64'hABCD_0000_0000_0000);
      chk("sh_we", s_we, 1'b1);
      chk("sh_stalls", stalls, 1);

      // misaligned LW
      step(); drive_op(mk_ir(3'd2, OP_LOAD), 64'h1002, 64'h0);
      @(negedge clk); chk("mis_stall", V_MEM_STALL, 1'b0);
      step(); MEM_V = 0;
      @(negedge clk);
      chk("mis_flag", WB_MISALIGN, 1'b1);
      chk("mis_wb_v", WB_V, 1'b1);
      chk("mis_req", DMEM_REQ, 1'b0);

      // load funct3=7 is not a memory op
      step(); drive_op(mk_ir(3'd7, OP_LOAD), 64'h1001, 64'h0);
      step(); MEM_V = 0;
      @(negedge clk); chk("f3_7_req", DMEM_REQ, 1'b0);

      // ACK while idle is ignored
      step(); DMEM_ACK = 1; DMEM_RDATA = 64'hFFFF;
      step(); DMEM_ACK = 0;
      @(negedge clk); chk("idle_ack_wb_v", WB_V, 1'b0);

      // table of further accesses
      foreach (vecs[i])
         do_mem(vecs[i].f3, vecs[i].st, vecs[i].addr, vecs[i].sr2, vecs[i].rdata,
                vecs[i].delay, stalls, s_addr, s_wdata, s_strb, s_we);
      chk("lhu_pin", ref_load(3'd5, 6, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);

      // LD with ACK withheld: bus error after TO request cycles
      step(); drive_op(mk_ir(3'd3, OP_LOAD), 64'h8000, 64'h0); DMEM_ACK = 0;
      reqs = 0;
      for (int k = 0; k < 3 * TO; k++) begin
         step();
         @(negedge clk);
         if (DMEM_REQ) reqs++;
         else break;
      end
      chk("to_req_cycles", reqs, TO);
      chk("to_buserr", WB_BUSERR, 1'b1);
      chk("to_wb_v", WB_V, 1'b1);
      chk("to_mem_data", WB_MEM_DATA, 64'd0);
      chk("to_state_idle", dbg_state, 1'b0);
      MEM_V = 0;

      // reset in WAIT abandons the access; a late ACK is ignored
      step(); drive_op(mk_ir(3'd3, OP_LOAD), 64'h7000, 64'h0);
      step();
      @(negedge clk); chk("rst_pre_req", DMEM_REQ, 1'b1);
      step(); RESET = 1;
      step(); RESET = 0; MEM_V = 0;
      @(negedge clk);
      chk("rst_req", DMEM_REQ, 1'b0);
      chk("rst_wb_v", WB_V, 1'b0);
      chk("rst_wb_ir", WB_IR, 32'd0);
      chk("rst_state", dbg_state, 1'b0);
      step(); DMEM_ACK = 1; DMEM_RDATA = 64'h1234;
      step(); DMEM_ACK = 0;
      @(negedge clk);
      chk("late_ack_wb_v", WB_V, 1'b0);
      chk("late_ack_req", DMEM_REQ, 1'b0);

      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
